// File: rtl/caixa_dagua_pkg.sv
// Shared definitions for the water tank controllers (level FSM and pump sequencer):
// 3-bit state codes, the state enum and the default timing constants.
package caixa_dagua_pkg;

  localparam logic [2:0] ST_OCIOSO    = 3'd0;
  localparam logic [2:0] ST_ABRE_VALV = 3'd1;
  localparam logic [2:0] ST_BOMBEANDO = 3'd2;
  localparam logic [2:0] ST_REPOUSO   = 3'd3;
  localparam logic [2:0] ST_FALHA     = 3'd4;

  typedef enum logic [2:0] {
    S_OCIOSO    = ST_OCIOSO,
    S_ABRE_VALV = ST_ABRE_VALV,
    S_BOMBEANDO = ST_BOMBEANDO,
    S_REPOUSO   = ST_REPOUSO,
    S_FALHA     = ST_FALHA
  } estado_e;

  localparam int CNT_W_DEF     = 16;
  localparam int T_PARTIDA_DEF = 50;
  localparam int T_MIN_ON_DEF  = 1000;
  localparam int T_MIN_OFF_DEF = 2000;
  localparam int T_SECO_DEF    = 500;

endpackage

// File: rtl/sequenciador_bomba_sincronizador_2ff.sv
// Two-flop synchroniser for one asynchronous level input; resets to 0.
module sincronizador_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sinc_q;

  // Capture the raw input, then re-time it once more before use
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sinc_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;

endmodule

// File: rtl/sequenciador_bomba.sv
// Pump / inlet valve sequencer for the lower-to-upper tank transfer.
// Valve opens before the pump, minimum on and off times are enforced, and a dry
// lower tank stops the pump.
// Optional feature macro: DRY_RUN_PROT_EN -- when defined, a dry lower tank is
// tolerated for T_SECO-1 consecutive cycles and the T_SECO-th trips a latched
// fault (S_FALHA) that needs rearme; when undefined, dry stops the pump at once.
//
// state       | meaning
// S_OCIOSO    | idle, everything off, waiting for a valid request
// S_ABRE_VALV | valve open, pump not yet started
// S_BOMBEANDO | pumping, valve open
// S_REPOUSO   | forced rest, requests ignored
// S_FALHA     | dry-run fault latched, waiting for rearme
module sequenciador_bomba
  import caixa_dagua_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int T_PARTIDA = T_PARTIDA_DEF,
  parameter int T_MIN_ON  = T_MIN_ON_DEF,
  parameter int T_MIN_OFF = T_MIN_OFF_DEF,
  parameter int T_SECO    = T_SECO_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pedido_bomba,
  input  logic       agua_inf_min,
  input  logic       agua_sup_cheia,
  input  logic       rearme,
  output logic       bomba,
  output logic       valvula,
  output logic       falha_seco,
  output logic [2:0] estado
);

  localparam logic [CNT_W-1:0] TC_PARTIDA = CNT_W'(T_PARTIDA - 1);
  localparam logic [CNT_W-1:0] TC_MIN_ON  = CNT_W'(T_MIN_ON - 1);
  localparam logic [CNT_W-1:0] TC_MIN_OFF = CNT_W'(T_MIN_OFF - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = '1;

  logic pedido_s, inf_s, sup_s;

  estado_e          state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             bomba_q, valvula_q;

  sincronizador_2ff u_sinc_pedido (.clk(clk), .reset_n(reset_n), .d_i(pedido_bomba),   .q_o(pedido_s));
  sincronizador_2ff u_sinc_inf    (.clk(clk), .reset_n(reset_n), .d_i(agua_inf_min),   .q_o(inf_s));
  sincronizador_2ff u_sinc_sup    (.clk(clk), .reset_n(reset_n), .d_i(agua_sup_cheia), .q_o(sup_s));

`ifdef DRY_RUN_PROT_EN
  localparam logic [CNT_W-1:0] TC_SECO = CNT_W'(T_SECO - 1);

  logic             rearme_s;
  logic [CNT_W-1:0] seco_q, seco_d;
  logic             falha_q;

  sincronizador_2ff u_sinc_rearme (.clk(clk), .reset_n(reset_n), .d_i(rearme), .q_o(rearme_s));
`else
  localparam int unused_t_seco = T_SECO;
  logic unused_rearme;
  assign unused_rearme = rearme;
`endif

  // Next-state rules, timer and dry-run counter updates
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OCIOSO: begin
        if (pedido_s && inf_s && !sup_s) state_d = S_ABRE_VALV;
      end
      S_ABRE_VALV: begin
        if (!pedido_s || !inf_s)      state_d = S_REPOUSO;
        else if (timer_q == TC_PARTIDA) state_d = S_BOMBEANDO;
      end
      S_BOMBEANDO: begin
        // Dry exit outranks the minimum on-time; a normal stop waits for it
`ifdef DRY_RUN_PROT_EN
        if (!inf_s && (seco_q == TC_SECO)) state_d = S_FALHA;
`else
        if (!inf_s) state_d = S_REPOUSO;
`endif
        else if ((!pedido_s || sup_s) && (timer_q >= TC_MIN_ON)) state_d = S_REPOUSO;
      end
      S_REPOUSO: begin
        if (timer_q == TC_MIN_OFF) state_d = S_OCIOSO;
      end
      S_FALHA: begin
`ifdef DRY_RUN_PROT_EN
        if (rearme_s) state_d = S_REPOUSO;
`else
        state_d = S_OCIOSO;
`endif
      end
      default: state_d = S_OCIOSO;
    endcase

    if (state_d != state_q)       timer_d = '0;
    else if (timer_q == TIMER_MAX) timer_d = timer_q;
    else                           timer_d = timer_q + CNT_W'(1);

`ifdef DRY_RUN_PROT_EN
    // Only consecutive dry cycles inside one pumping run count
    if ((state_q == S_BOMBEANDO) && (state_d == S_BOMBEANDO) && !inf_s)
      seco_d = seco_q + CNT_W'(1);
    else
      seco_d = '0;
`endif
  end

  // State register with outputs registered from the next state (Moore, change on entry)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_OCIOSO;
      timer_q   <= '0;
      bomba_q   <= 1'b0;
      valvula_q <= 1'b0;
`ifdef DRY_RUN_PROT_EN
      seco_q    <= '0;
      falha_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bomba_q   <= (state_d == S_BOMBEANDO);
      valvula_q <= (state_d == S_ABRE_VALV) || (state_d == S_BOMBEANDO);
`ifdef DRY_RUN_PROT_EN
      seco_q    <= seco_d;
      falha_q   <= (state_d == S_FALHA);
`endif
    end
  end

  assign bomba   = bomba_q;
  assign valvula = valvula_q;
  assign estado  = state_q;
`ifdef DRY_RUN_PROT_EN
  assign falha_seco = falha_q;
`else
  assign falha_seco = 1'b0;
`endif

endmodule

// File: tb/tb_sequenciador_bomba.sv
// Bench for sequenciador_bomba: directed start-up / minimum-on / reset sequences
// followed by randomized input segments, all checked against a reference model.
// Honours DRY_RUN_PROT_EN the same way the design does.
module tb_sequenciador_bomba;

  localparam int T_PARTIDA = 4;
  localparam int T_MIN_ON  = 10;
  localparam int T_MIN_OFF = 8;
  localparam int T_SECO    = 5;

  logic       clk;
  logic       reset_n;
  logic       pedido_bomba, agua_inf_min, agua_sup_cheia, rearme;
  logic       bomba, valvula, falha_seco;
  logic [2:0] estado;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase (spec state code), cycles spent in it, consecutive dry cycles,
  // and the two-cycle input latency as a pair of delayed input snapshots {p,inf,sup,rea}.
  int       m_est, m_t, m_dry;
  logic [3:0] s1, s2;

  sequenciador_bomba #(
    .CNT_W(16), .T_PARTIDA(T_PARTIDA), .T_MIN_ON(T_MIN_ON),
    .T_MIN_OFF(T_MIN_OFF), .T_SECO(T_SECO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pedido_bomba(pedido_bomba), .agua_inf_min(agua_inf_min),
    .agua_sup_cheia(agua_sup_cheia), .rearme(rearme),
    .bomba(bomba), .valvula(valvula), .falha_seco(falha_seco), .estado(estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired, CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int obs, input int esp);
    n_checks++;
    if (obs != esp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  task automatic modelo_reset();
    m_est = 0; m_t = 0; m_dry = 0; s1 = '0; s2 = '0;
  endtask

  // One clock edge of the reference behaviour, using inputs as seen two cycles late
  task automatic modelo_passo(input logic [3:0] cur);
    logic p, inf, sup, rea;
    int   prox;
    {p, inf, sup, rea} = s2;
    prox = m_est;
    case (m_est)
      0: if (p && inf && !sup) prox = 1;
      1: begin
        if (!p || !inf) prox = 3;
        else if (m_t + 1 == T_PARTIDA) prox = 2;
      end
      2: begin
`ifdef DRY_RUN_PROT_EN
        if (!inf && (m_dry + 1 == T_SECO)) prox = 4;
`else
        if (!inf) prox = 3;
`endif
        else if ((!p || sup) && (m_t + 1 >= T_MIN_ON)) prox = 3;
      end
      3: if (m_t + 1 == T_MIN_OFF) prox = 0;
      4: if (rea) prox = 3;
      default: prox = 0;
    endcase
    m_dry = (m_est == 2 && prox == 2 && !inf) ? m_dry + 1 : 0;
    m_t   = (prox != m_est) ? 0 : m_t + 1;
    m_est = prox;
    s2 = s1;
    s1 = cur;
  endtask

  task automatic compara();
    check_eq("estado",     estado,     m_est);
    check_eq("bomba",      bomba,      (m_est == 2) ? 1 : 0);
    check_eq("valvula",    valvula,    (m_est == 1 || m_est == 2) ? 1 : 0);
    check_eq("falha_seco", falha_seco, (m_est == 4) ? 1 : 0);
  endtask

  // Edge, model step, drive new inputs just after the edge, check on the falling edge
  task automatic ciclo(input logic p, input logic inf, input logic sup, input logic rea);
    @(posedge clk);
    modelo_passo({pedido_bomba, agua_inf_min, agua_sup_cheia, rearme});
    #1;
    pedido_bomba = p; agua_inf_min = inf; agua_sup_cheia = sup; rearme = rea;
    @(negedge clk);
    compara();
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock edge
  task automatic reset_assincrono();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_eq("rst_bomba",   bomba,      0);
    check_eq("rst_valvula", valvula,    0);
    check_eq("rst_falha",   falha_seco, 0);
    check_eq("rst_estado",  estado,     0);
    modelo_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic p, inf, sup, rea;
    int   len;

    reset_n = 1'b0;
    pedido_bomba = 1'b0; agua_inf_min = 1'b0; agua_sup_cheia = 1'b0; rearme = 1'b0;
    modelo_reset();
    #23;
    check_eq("reset_estado",  estado,     0);
    check_eq("reset_bomba",   bomba,      0);
    check_eq("reset_valvula", valvula,    0);
    check_eq("reset_falha",   falha_seco, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) ciclo(1'b0, 1'b1, 1'b0, 1'b0);

    // Start-up, then pedido drops two cycles after the pump starts
    for (int k = 0; k <= 27; k++) begin
      ciclo((k >= 9) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 2)  check_eq("partida_valv_cedo",  valvula, 0);
      if (k == 3)  check_eq("partida_valv",       valvula, 1);
      if (k == 6)  check_eq("partida_bomba_cedo", bomba,   0);
      if (k == 7)  check_eq("partida_bomba",      bomba,   1);
      if (k == 7)  check_eq("partida_estado",     estado,  2);
      if (k == 16) check_eq("min_on_mantem",      bomba,   1);
      if (k == 17) check_eq("min_on_para",        bomba,   0);
      if (k == 17) check_eq("repouso_entra",      estado,  3);
      if (k == 24) check_eq("repouso_fim",        estado,  3);
      if (k == 25) check_eq("ocioso_volta",       estado,  0);
    end

    // Reset while pumping, then the full start-up repeats
    for (int k = 0; k < 10; k++) ciclo(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("pre_reset_bombeando", estado, 2);
    reset_assincrono();
    for (int j = 1; j <= 8; j++) begin
      ciclo(1'b1, 1'b1, 1'b0, 1'b0);
      if (j == 2) check_eq("rep_valv_cedo",  valvula, 0);
      if (j == 3) check_eq("rep_valv",       valvula, 1);
      if (j == 6) check_eq("rep_bomba_cedo", bomba,   0);
      if (j == 7) check_eq("rep_bomba",      bomba,   1);
    end

    // Randomized held segments; dry spells kept short so both sides of T_SECO occur
    for (int seg = 0; seg < 250; seg++) begin
      p   = ($urandom_range(0, 3) != 0);
      inf = ($urandom_range(0, 4) != 0);
      sup = ($urandom_range(0, 4) == 0);
      rea = ($urandom_range(0, 2) == 0);
      len = inf ? $urandom_range(1, 25) : $urandom_range(1, 7);
      for (int c = 0; c < len; c++) ciclo(p, inf, sup, rea);
      if (m_est == 2 && $urandom_range(0, 9) == 0) reset_assincrono();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
